icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 89 ++++++++
 tb/tb_icache.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking COMPARE/FETCH miss FSM.
// Hits are answered combinationally; a miss fetches one word from memory and refills its frame.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] COMPARE = 1'b0;
  localparam logic [0:0] FETCH   = 1'b1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } frame_t;

  frame_t            frames [SETS];
  logic [SETS-1:0]   valid;
  logic [0:0]        state;
  logic [31:0]       miss_addr;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  frame_t            cur;
  logic              fill_en;
  logic              unused_bits;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[31:IDX_W+2];
  assign cur      = frames[req_idx];
  // byte offset never selects anything: every frame holds exactly one word
  assign unused_bits = ^imemaddr[1:0];

  assign ihit     = (state == COMPARE) && imemREN && valid[req_idx] && (cur.tag == req_tag);
  assign imemload = ihit ? cur.data : 32'd0;
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? miss_addr : 32'd0;
  assign fill_en  = (state == FETCH) && !iwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= COMPARE;
      miss_addr  <= 32'd0;
      valid      <= '0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      case (state)
        COMPARE: begin
          if (imemREN && !ihit) begin
            miss_addr <= {imemaddr[31:2], 2'b00};
            state     <= FETCH;
          end
        end
        default: begin
          // fill completes even if the datapath dropped or redirected its request
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            miss_count      <= miss_count + 32'd1;
            state           <= COMPARE;
          end
        end
      endcase
    end
  end

  // Tag/data payload needs no reset; visibility is gated by valid.
  always_ff @(posedge CLK) begin
    if (fill_en) frames[fill_idx] <= '{tag: fill_tag, data: iload};
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (SETS=16): cold miss, conflict, idle, redirect, reset mid-fill, streaming.
module tb_icache;
  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int vecs = 0;
  int miscompares = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  // Caller is in the low clock phase; drives a miss and completes its fill after nwait busy cycles.
  task automatic miss_fill(input logic [31:0] addr, input int nwait, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    @(posedge CLK);
    repeat (nwait) begin @(negedge CLK); @(posedge CLK); end
    @(negedge CLK); iwait = 1'b0; iload = data;
    @(posedge CLK);
    #1 iwait = 1'b1;
    exp_miss++;
  endtask

  task automatic test_reset;
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'd0; iwait = 1'b1; iload = 32'd0;
    @(negedge CLK); #1;
    vecs++; if ({ihit, iREN} !== 2'b00) begin miscompares++; $display("FAIL reset_hit_ren: got %b want 00", {ihit, iREN}); end
    vecs++; if ({imemload, iaddr} !== 64'd0) begin miscompares++; $display("FAIL reset_load_addr: got %h want 0", {imemload, iaddr}); end
    vecs++; if ({hit_count, miss_count} !== 64'd0) begin miscompares++; $display("FAIL reset_counts: got %h want 0", {hit_count, miss_count}); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_cold_miss;
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1; #1;
    vecs++; if ({ihit, iREN} !== 2'b00) begin miscompares++; $display("FAIL cold_lookup: got %b want 00", {ihit, iREN}); end
    @(posedge CLK);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); iwait = (i < 3); iload = (i == 3) ? 32'h8C220004 : 32'hFFFF_FFFF; #1;
      vecs++; if ({ihit, iREN, iaddr} !== {2'b01, 32'h40}) begin miscompares++; $display("FAIL cold_fetch%0d: got %b/%b/%h want 0/1/00000040", i, ihit, iREN, iaddr); end
      @(posedge CLK);
    end
    exp_miss = 1;
    @(negedge CLK); iwait = 1'b1; #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h8C220004}) begin miscompares++; $display("FAIL cold_hit: got %b/%h want 1/8c220004", ihit, imemload); end
    vecs++; if ({iREN, iaddr} !== 33'd0) begin miscompares++; $display("FAIL cold_ren_after: got %b/%h want 0/0", iREN, iaddr); end
    vecs++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin miscompares++; $display("FAIL cold_counts_fill: got %0d/%0d want 1/0", miss_count, hit_count); end
    @(posedge CLK); exp_hit = 1;
    @(negedge CLK); #1;
    vecs++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin miscompares++; $display("FAIL cold_counts_hit: got %0d/%0d want 1/1", hit_count, miss_count); end
    imemREN = 1'b0;
  endtask

  task automatic test_conflict;
    @(negedge CLK); miss_fill(32'h440, 2, 32'h1111_0440);
    @(negedge CLK); #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h1111_0440}) begin miscompares++; $display("FAIL conflict_hit440: got %b/%h want 1/11110440", ihit, imemload); end
    @(posedge CLK); exp_hit++;
    @(negedge CLK); imemaddr = 32'h40; #1;
    vecs++; if ({ihit, imemload} !== 33'd0) begin miscompares++; $display("FAIL conflict_evicted40: got %b/%h want 0/0", ihit, imemload); end
    miss_fill(32'h40, 0, 32'h2222_0040);
    @(negedge CLK); #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h2222_0040}) begin miscompares++; $display("FAIL conflict_refill40: got %b/%h want 1/22220040", ihit, imemload); end
    vecs++; if (miss_count !== 32'd3) begin miscompares++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
    imemaddr = 32'h440; #1;
    vecs++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL conflict_evicted440: got %b want 0", ihit); end
    imemREN = 1'b0;
  endtask

  task automatic test_idle;
    @(negedge CLK); imemREN = 1'b0; imemaddr = 32'h40; #1;
    vecs++; if ({ihit, imemload, iREN, iaddr} !== 66'd0) begin miscompares++; $display("FAIL idle_outputs: got %b/%h/%b/%h want 0/0/0/0", ihit, imemload, iREN, iaddr); end
    @(posedge CLK); @(negedge CLK); #1;
    vecs++; if (hit_count !== exp_hit || iREN !== 1'b0) begin miscompares++; $display("FAIL idle_hold: got %0d/%b want %0d/0", hit_count, iREN, exp_hit); end
    imemREN = 1'b1; #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h2222_0040}) begin miscompares++; $display("FAIL idle_still_cached: got %b/%h want 1/22220040", ihit, imemload); end
    imemREN = 1'b0;
  endtask

  task automatic test_redirect;
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1; #1;
    vecs++; if (ihit !== 1'b0) begin miscompares++; $display("FAIL redir_miss100: got %b want 0", ihit); end
    @(posedge CLK);
    @(negedge CLK); imemaddr = 32'h200; #1;
    vecs++; if ({ihit, iREN, iaddr} !== {2'b01, 32'h100}) begin miscompares++; $display("FAIL redir_hold_addr: got %b/%b/%h want 0/1/00000100", ihit, iREN, iaddr); end
    @(posedge CLK);
    @(negedge CLK); iwait = 1'b0; iload = 32'h3333_0100; #1;
    vecs++; if (iaddr !== 32'h100) begin miscompares++; $display("FAIL redir_fill_addr: got %h want 00000100", iaddr); end
    @(posedge CLK); exp_miss++;
    @(negedge CLK); iwait = 1'b1; #1;
    vecs++; if ({ihit, iREN} !== 2'b00) begin miscompares++; $display("FAIL redir_new_lookup: got %b want 00", {ihit, iREN}); end
    @(posedge CLK);
    @(negedge CLK); #1;
    vecs++; if ({iREN, iaddr} !== {1'b1, 32'h200}) begin miscompares++; $display("FAIL redir_new_fetch: got %b/%h want 1/00000200", iREN, iaddr); end
    iwait = 1'b0; iload = 32'h4444_0200;
    @(posedge CLK); exp_miss++;
    @(negedge CLK); iwait = 1'b1; #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h4444_0200}) begin miscompares++; $display("FAIL redir_hit200: got %b/%h want 1/44440200", ihit, imemload); end
    vecs++; if (miss_count !== exp_miss) begin miscompares++; $display("FAIL redir_miss_count: got %0d want %0d", miss_count, exp_miss); end
    imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
    @(posedge CLK);
    @(negedge CLK); #1;
    vecs++; if (iREN !== 1'b1) begin miscompares++; $display("FAIL rstfill_in_fetch: got %b want 1", iREN); end
    RST = 1'b1; #1;
    vecs++; if ({ihit, iREN, iaddr} !== 34'd0) begin miscompares++; $display("FAIL rstfill_async: got %b/%b/%h want 0/0/0", ihit, iREN, iaddr); end
    vecs++; if ({hit_count, miss_count} !== 64'd0) begin miscompares++; $display("FAIL rstfill_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    iwait = 1'b0; iload = 32'hDEAD_BEEF;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0; iwait = 1'b1; exp_hit = 0; exp_miss = 0; #1;
    vecs++; if ({ihit, iREN} !== 2'b00) begin miscompares++; $display("FAIL rstfill_remiss: got %b want 00", {ihit, iREN}); end
    miss_fill(32'h100, 1, 32'h5555_0100);
    @(negedge CLK); #1;
    vecs++; if ({ihit, imemload} !== {1'b1, 32'h5555_0100}) begin miscompares++; $display("FAIL rstfill_hit: got %b/%h want 1/55550100", ihit, imemload); end
    vecs++; if (miss_count !== 32'd1) begin miscompares++; $display("FAIL rstfill_miss_count: got %0d want 1", miss_count); end
    imemREN = 1'b0;
  endtask

  task automatic test_back_to_back;
    int hits_seen;
    for (int a = 0; a < 16; a++) begin
      @(negedge CLK); miss_fill(a * 4, a % 3, 32'hC0DE_0000 | (a * 4));
    end
    @(negedge CLK); #1;
    vecs++; if (miss_count !== exp_miss) begin miscompares++; $display("FAIL stream_fills: got %0d want %0d", miss_count, exp_miss); end
    hits_seen = 0;
    for (int a = 0; a < 16; a++) begin
      imemREN = 1'b1; imemaddr = a * 4; #1;
      if (ihit === 1'b1 && imemload === (32'hC0DE_0000 | (a * 4)) && iREN === 1'b0) hits_seen++;
      else $display("FAIL stream_word%0d: got %b/%h/%b want 1/%h/0", a, ihit, imemload, iREN, 32'hC0DE_0000 | (a * 4));
      @(posedge CLK); exp_hit++;
      @(negedge CLK);
    end
    vecs++; if (hits_seen !== 16) begin miscompares++; $display("FAIL stream_consecutive: got %0d want 16", hits_seen); end
    imemREN = 1'b0; #1;
    vecs++; if (hit_count !== exp_hit || miss_count !== exp_miss) begin miscompares++; $display("FAIL stream_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, exp_hit, exp_miss); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_conflict;
    test_idle;
    test_redirect;
    test_reset_mid_fill;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
